stack_ctrl_5bit: RTL and testbench

//   Moore FSM controller directly upstream of the 5-bit up/down counter. Converts

---
 rtl/stack_ctrl_5bit.sv | 170 +++++++++++++++++
 tb/tb_stack_ctrl_5bit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_5bit.sv
// stack_ctrl_5bit
//   Moore controller sitting in front of a CNT_W-bit up/down counter and a
//   2**CNT_W-entry stack memory. Push, pop and clear requests become
//   single-cycle counter pulses (cntU / cntD / rst5) and memory strobes. The
//   counter's value is used as the stack pointer and its down_done flag as the
//   empty indication.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   push_req   level push request, held until push_ack
//   pop_req    level pop request, held until pop_ack
//   clear      level clear request, held until clr_ack
//   cnt_val    counter value (occupancy / next free slot)
//   down_done  counter flag, cnt_val == 0
//   cntU       counter increment pulse
//   cntD       counter decrement pulse
//   rst5       counter synchronous clear pulse
//   mem_we     stack memory write strobe
//   mem_re     stack memory read strobe
//   mem_addr   stack memory address (0 outside PUSH / POP_RD)
//   push_ack   push completed or rejected (one cycle)
//   pop_ack    pop completed or rejected (one cycle)
//   clr_ack    clear completed (one cycle)
//   full       cnt_val == 2**CNT_W-1
//   empty      equals down_done
//   err_ovf    sticky overflow flag (push while full), cleared by clear
//   err_unf    sticky underflow flag (pop while empty), cleared by clear
module stack_ctrl_5bit #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             clear,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             down_done,
  output logic             cntU,
  output logic             cntD,
  output logic             rst5,
  output logic             mem_we,
  output logic             mem_re,
  output logic [CNT_W-1:0] mem_addr,
  output logic             push_ack,
  output logic             pop_ack,
  output logic             clr_ack,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [CNT_W-1:0] MAX_OCC = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH    = 3'd1,
    POP_DEC = 3'd2,
    POP_RD  = 3'd3,
    CLR     = 3'd4,
    REJ     = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Remembers which request was rejected so REJ acks the right requester.
  logic rej_push, rej_push_nxt;
  logic set_ovf, set_unf;

  assign full  = (cnt_val == MAX_OCC);
  assign empty = down_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rej_push <= 1'b0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rej_push <= rej_push_nxt;
      // Clear wins; CLR is never entered in the same cycle as a set.
      if (state == CLR) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end else begin
        if (set_ovf) err_ovf <= 1'b1;
        if (set_unf) err_unf <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    rej_push_nxt = rej_push;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    case (state)
      IDLE: begin
        // Priority clear > push > pop; a simultaneous pop waits for a later visit.
        if (clear) begin
          state_nxt = CLR;
        end else if (push_req) begin
          rej_push_nxt = 1'b1;
          if (full) begin
            state_nxt = REJ;
            set_ovf   = 1'b1;
          end else begin
            state_nxt = PUSH;
          end
        end else if (pop_req) begin
          rej_push_nxt = 1'b0;
          if (empty) begin
            state_nxt = REJ;
            set_unf   = 1'b1;
          end else begin
            state_nxt = POP_DEC;
          end
        end
      end
      PUSH:    state_nxt = IDLE;
      POP_DEC: state_nxt = POP_RD;
      POP_RD:  state_nxt = IDLE;
      CLR:     state_nxt = IDLE;
      REJ:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: everything except the address is a pure state decode.
  always_comb begin
    cntU     = 1'b0;
    cntD     = 1'b0;
    rst5     = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    push_ack = 1'b0;
    pop_ack  = 1'b0;
    clr_ack  = 1'b0;
    case (state)
      PUSH: begin
        mem_we   = 1'b1;
        mem_addr = cnt_val;
        cntU     = 1'b1;
        push_ack = 1'b1;
      end
      POP_DEC: begin
        cntD = 1'b1;
      end
      POP_RD: begin
        // Counter was decremented at the end of POP_DEC, so it points at the top entry.
        mem_re   = 1'b1;
        mem_addr = cnt_val;
        pop_ack  = 1'b1;
      end
      CLR: begin
        rst5    = 1'b1;
        clr_ack = 1'b1;
      end
      REJ: begin
        push_ack = rej_push;
        pop_ack  = ~rej_push;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl_5bit.sv
// Testbench for stack_ctrl_5bit: drives push/pop/clear requests, emulates the
// downstream counter, and compares against a stack-occupancy reference model.
module tb_stack_ctrl_5bit;

  localparam int CNT_W = 5;
  localparam int MAXO  = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_req, pop_req, clear;
  logic [CNT_W-1:0] cnt_val;
  logic             down_done;
  logic             cntU, cntD, rst5, mem_we, mem_re;
  logic [CNT_W-1:0] mem_addr;
  logic             push_ack, pop_ack, clr_ack, full, empty, err_ovf, err_unf;

  int total = 0;
  int bad   = 0;

  stack_ctrl_5bit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req), .clear(clear),
    .cnt_val(cnt_val), .down_done(down_done), .cntU(cntU), .cntD(cntD), .rst5(rst5),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .push_ack(push_ack),
    .pop_ack(pop_ack), .clr_ack(clr_ack), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // Downstream 5-bit counter (environment, reset by its own reset).
  logic [CNT_W-1:0] occ;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       occ <= '0;
    else if (rst5)                  occ <= '0;
    else if (cntU && occ != 5'd31)  occ <= occ + 5'd1;
    else if (cntD && occ != 5'd0)   occ <= occ - 5'd1;
  end
  assign cnt_val   = occ;
  assign down_done = (occ == 5'd0);

  typedef struct {
    int n_u, n_d, n_r5, n_we, n_re;
    int we_addr, re_addr;
    int pa, qa, ca, first_ack, lat;
    int d_cyc, re_cyc, viol, to;
  } obs_t;

  typedef struct {
    int n_u, n_d, n_r5, we_addr, re_addr, pa, qa, ca, first_ack, lat;
  } exp_t;

  // Reference model state: stack occupancy and sticky error flags.
  int m_occ = 0;
  bit m_ovf = 0, m_unf = 0;

  task automatic model_op(input bit p, input bit q, input bit c, output exp_t e);
    e = '{default: 0};
    e.we_addr = -1; e.re_addr = -1; e.first_ack = -1;
    if (c) begin
      e.n_r5 = 1; e.ca = 1; e.lat = 1; e.first_ack = 2;
      m_occ = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (p) begin
        e.pa = 1; e.first_ack = 0; e.lat += 1;
        if (m_occ == MAXO) m_ovf = 1;
        else begin e.n_u = 1; e.we_addr = m_occ; m_occ++; end
      end
      if (p && q) e.lat += 1;   // back through IDLE before the pop is seen
      if (q) begin
        e.qa = 1;
        if (e.first_ack < 0) e.first_ack = 1;
        if (m_occ == 0) begin m_unf = 1; e.lat += 1; end
        else begin e.n_d = 1; e.re_addr = m_occ - 1; m_occ--; e.lat += 2; end
      end
    end
  endtask

  // Drives one request set (starting just after a negedge) until every request
  // has been acked, dropping each one as its ack is seen, then idles a cycle.
  task automatic run_op(input bit p, input bit q, input bit c, output obs_t o);
    o = '{default: 0};
    o.we_addr = -1; o.re_addr = -1; o.first_ack = -1;
    push_req = p; pop_req = q; clear = c;
    for (int i = 1; i <= 12 && (push_req || pop_req || clear); i++) begin
      @(negedge clk);
      o.lat = i;
      if (cntU) o.n_u++;
      if (cntD) begin o.n_d++; o.d_cyc = i; end
      if (rst5) o.n_r5++;
      if (mem_we) begin o.n_we++; o.we_addr = int'(mem_addr); end
      if (mem_re) begin o.n_re++; o.re_addr = int'(mem_addr); o.re_cyc = i; end
      if (int'(cntU) + int'(cntD) + int'(rst5) > 1) o.viol++;
      if (!mem_we && !mem_re && mem_addr != '0) o.viol++;
      if (push_ack) begin o.pa++; push_req = 1'b0; if (o.first_ack < 0) o.first_ack = 0; end
      if (pop_ack)  begin o.qa++; pop_req  = 1'b0; if (o.first_ack < 0) o.first_ack = 1; end
      if (clr_ack)  begin o.ca++; clear    = 1'b0; if (o.first_ack < 0) o.first_ack = 2; end
    end
    if (push_req || pop_req || clear) o.to = 1;
    push_req = 1'b0; pop_req = 1'b0; clear = 1'b0;
    @(negedge clk);
    if ({cntU, cntD, rst5, mem_we, mem_re, push_ack, pop_ack, clr_ack, mem_addr} != '0) o.viol++;
  endtask

  task automatic test_reset();
    rst = 1'b0; push_req = 1'b0; pop_req = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({cntU, cntD, rst5, mem_we, mem_re, push_ack, pop_ack, clr_ack, err_ovf, err_unf, mem_addr} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {cntU, cntD, rst5, mem_we, mem_re, push_ack, pop_ack, clr_ack, err_ovf, err_unf, mem_addr}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({full, empty} !== 2'b01) begin bad++; $display("FAIL reset_full_empty got=%b exp=01", {full, empty}); end
    total++; if ({cntU, mem_we, push_ack, err_ovf, err_unf} !== 5'b0) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=0", {cntU, mem_we, push_ack, err_ovf, err_unf}); end
    m_occ = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_push3();
    obs_t o; exp_t e;
    for (int k = 0; k < 3; k++) begin
      run_op(1, 0, 0, o); model_op(1, 0, 0, e);
      total++; if (o.we_addr !== k || o.n_we !== 1) begin bad++; $display("FAIL push%0d_addr got=%0d/%0d exp=%0d/1", k, o.we_addr, o.n_we, k); end
      total++; if (o.n_u !== 1 || o.pa !== 1 || o.lat !== 1) begin
        bad++; $display("FAIL push%0d_pulses cntU=%0d ack=%0d lat=%0d exp 1/1/1", k, o.n_u, o.pa, o.lat); end
      total++; if (o.viol !== 0 || o.to !== 0) begin bad++; $display("FAIL push%0d_hygiene viol=%0d to=%0d exp 0", k, o.viol, o.to); end
    end
    total++; if (int'(cnt_val) !== 3) begin bad++; $display("FAIL push3_occ got=%0d exp=3", cnt_val); end
  endtask

  task automatic test_pop();
    obs_t o; exp_t e;
    run_op(0, 1, 0, o); model_op(0, 1, 0, e);
    total++; if (o.n_d !== 1 || o.d_cyc !== 1) begin bad++; $display("FAIL pop_cntD n=%0d cyc=%0d exp 1/1", o.n_d, o.d_cyc); end
    total++; if (o.re_addr !== 2 || o.re_cyc !== 2 || o.n_re !== 1) begin
      bad++; $display("FAIL pop_read addr=%0d cyc=%0d n=%0d exp 2/2/1", o.re_addr, o.re_cyc, o.n_re); end
    total++; if (o.qa !== 1 || o.lat !== 2 || o.n_u !== 0) begin bad++; $display("FAIL pop_ack ack=%0d lat=%0d cntU=%0d exp 1/2/0", o.qa, o.lat, o.n_u); end
    total++; if (int'(cnt_val) !== 2 || o.viol !== 0) begin bad++; $display("FAIL pop_occ got=%0d viol=%0d exp 2/0", cnt_val, o.viol); end
  endtask

  task automatic test_overflow_clear();
    obs_t o; exp_t e;
    int prev;
    while (m_occ < MAXO) begin
      prev = m_occ;
      run_op(1, 0, 0, o); model_op(1, 0, 0, e);
      total++; if (o.we_addr !== prev || o.n_u !== 1) begin bad++; $display("FAIL fill_addr got=%0d cntU=%0d exp=%0d/1", o.we_addr, o.n_u, prev); end
    end
    total++; if (full !== 1'b1 || err_ovf !== 1'b0) begin bad++; $display("FAIL fill_full full=%b ovf=%b exp 1/0", full, err_ovf); end
    run_op(1, 0, 0, o); model_op(1, 0, 0, e);
    total++; if (o.pa !== 1 || o.n_u !== 0 || o.n_we !== 0) begin
      bad++; $display("FAIL ovf_reject ack=%0d cntU=%0d we=%0d exp 1/0/0", o.pa, o.n_u, o.n_we); end
    total++; if (err_ovf !== 1'b1 || int'(cnt_val) !== MAXO) begin bad++; $display("FAIL ovf_flag ovf=%b occ=%0d exp 1/31", err_ovf, cnt_val); end
    run_op(0, 0, 1, o); model_op(0, 0, 1, e);
    total++; if (o.n_r5 !== 1 || o.ca !== 1 || o.lat !== 1 || o.n_u + o.n_d !== 0) begin
      bad++; $display("FAIL clear_pulse rst5=%0d ack=%0d lat=%0d ud=%0d exp 1/1/1/0", o.n_r5, o.ca, o.lat, o.n_u + o.n_d); end
    total++; if (err_ovf !== 1'b0 || int'(cnt_val) !== 0 || empty !== 1'b1) begin
      bad++; $display("FAIL clear_state ovf=%b occ=%0d empty=%b exp 0/0/1", err_ovf, cnt_val, empty); end
  endtask

  task automatic test_underflow();
    obs_t o; exp_t e;
    run_op(0, 1, 0, o); model_op(0, 1, 0, e);
    total++; if (o.qa !== 1 || o.n_d !== 0 || o.n_re !== 0 || o.lat !== 1) begin
      bad++; $display("FAIL unf_reject ack=%0d cntD=%0d re=%0d lat=%0d exp 1/0/0/1", o.qa, o.n_d, o.n_re, o.lat); end
    total++; if (err_unf !== 1'b1 || err_ovf !== 1'b0) begin bad++; $display("FAIL unf_flag unf=%b ovf=%b exp 1/0", err_unf, err_ovf); end
    run_op(1, 0, 0, o); model_op(1, 0, 0, e);
    run_op(0, 1, 0, o); model_op(0, 1, 0, e);
    total++; if (err_unf !== 1'b1 || o.re_addr !== 0) begin bad++; $display("FAIL unf_sticky unf=%b addr=%0d exp 1/0", err_unf, o.re_addr); end
    run_op(0, 0, 1, o); model_op(0, 0, 1, e);
    total++; if (err_unf !== 1'b0) begin bad++; $display("FAIL unf_clear unf=%b exp 0", err_unf); end
  endtask

  task automatic test_simultaneous();
    obs_t o; exp_t e;
    while (m_occ < 5) begin run_op(1, 0, 0, o); model_op(1, 0, 0, e); end
    run_op(1, 1, 0, o); model_op(1, 1, 0, e);
    total++; if (o.first_ack !== 0 || o.we_addr !== 5 || o.re_addr !== 5) begin
      bad++; $display("FAIL both_order first=%0d wa=%0d ra=%0d exp 0/5/5", o.first_ack, o.we_addr, o.re_addr); end
    total++; if (o.pa !== 1 || o.qa !== 1 || o.lat !== 4 || int'(cnt_val) !== 5) begin
      bad++; $display("FAIL both_acks pa=%0d qa=%0d lat=%0d occ=%0d exp 1/1/4/5", o.pa, o.qa, o.lat, cnt_val); end
  endtask

  task automatic test_async_reset();
    obs_t o; exp_t e;
    int acks = 0;
    pop_req = 1'b1;
    @(negedge clk);
    total++; if (cntD !== 1'b1) begin bad++; $display("FAIL arst_in_popdec cntD=%b exp 1", cntD); end
    #1 rst = 1'b0;
    #1;
    total++; if ({cntU, cntD, rst5, mem_we, mem_re, push_ack, pop_ack, clr_ack, mem_addr} !== '0) begin
      bad++; $display("FAIL arst_immediate got=%b exp=0", {cntU, cntD, rst5, mem_we, mem_re, push_ack, pop_ack, clr_ack, mem_addr}); end
    pop_req = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (pop_ack) acks++; end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (pop_ack || mem_re) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL arst_no_ack got=%0d exp=0", acks); end
    m_occ = 0; m_ovf = 0; m_unf = 0;
    run_op(1, 0, 0, o); model_op(1, 0, 0, e);
    total++; if (o.we_addr !== 0 || o.lat !== 1 || o.to !== 0) begin
      bad++; $display("FAIL arst_idle_after addr=%0d lat=%0d to=%0d exp 0/1/0", o.we_addr, o.lat, o.to); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    bit p, q, c;
    int r;
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 6);
      p = !c && (r < 58 || r >= 92);
      q = !c && (r >= 58);
      run_op(p, q, c, o); model_op(p, q, c, e);
      total++; if (o.n_u !== e.n_u || o.n_d !== e.n_d || o.n_r5 !== e.n_r5) begin
        bad++; $display("FAIL rnd%0d_pulses u/d/r5 got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, o.n_u, o.n_d, o.n_r5, e.n_u, e.n_d, e.n_r5); end
      total++; if (o.n_we !== e.n_u || o.n_re !== e.n_d || o.we_addr !== e.we_addr || o.re_addr !== e.re_addr) begin
        bad++; $display("FAIL rnd%0d_mem we=%0d@%0d re=%0d@%0d exp %0d@%0d %0d@%0d", k, o.n_we, o.we_addr, o.n_re, o.re_addr, e.n_u, e.we_addr, e.n_d, e.re_addr); end
      total++; if (o.pa !== e.pa || o.qa !== e.qa || o.ca !== e.ca || o.first_ack !== e.first_ack || o.lat !== e.lat) begin
        bad++; $display("FAIL rnd%0d_acks pa/qa/ca/first/lat got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", k, o.pa, o.qa, o.ca, o.first_ack, o.lat, e.pa, e.qa, e.ca, e.first_ack, e.lat); end
      total++; if (int'(cnt_val) !== m_occ || err_ovf !== m_ovf || err_unf !== m_unf || full !== (m_occ == MAXO) || empty !== (m_occ == 0)) begin
        bad++; $display("FAIL rnd%0d_state occ=%0d ovf=%b unf=%b full=%b empty=%b exp occ=%0d ovf=%b unf=%b", k, cnt_val, err_ovf, err_unf, full, empty, m_occ, m_ovf, m_unf); end
      total++; if (o.viol !== 0 || o.to !== 0) begin bad++; $display("FAIL rnd%0d_hygiene viol=%0d to=%0d exp 0/0", k, o.viol, o.to); end
    end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_pop();
    test_overflow_clear();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
